// File: rtl/mips_lite_pkg.sv
// mips_lite_pkg: constants shared by the register file and its writeback arbiter
package mips_lite_pkg;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/gpr_wb_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter that owns the last_grant register
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_q;
    logic last_d;
    // Grant the sole requester, or on a tie the one not served last; record the winner
    always_comb begin
        gnt[0] = !hold && req[0] && (!req[1] || last_q);
        gnt[1] = !hold && req[1] && (!req[0] || !last_q);
        last_d = gnt[1] ? 1'b1 : (gnt[0] ? 1'b0 : last_q);
    end
    // last_grant resets to 1 so req0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the gpr write port between two writeback requesters with forwarding
module gpr_wb_arbiter
    import mips_lite_pkg::*;
#(
    parameter int DW = mips_lite_pkg::DW,
    parameter int AW = mips_lite_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          wb0_valid,
    input  logic [AW-1:0] wb0_addr,
    input  logic [DW-1:0] wb0_data,
    output logic          wb0_ready,
    input  logic          wb1_valid,
    input  logic [AW-1:0] wb1_addr,
    input  logic [DW-1:0] wb1_data,
    output logic          wb1_ready,
    output logic          SIG_RF_W,
    output logic [AW-1:0] reg_write,
    output logic [DW-1:0] data_write,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic          fwd_hit1,
    output logic          fwd_hit2,
    output logic [DW-1:0] fwd_data1,
    output logic [DW-1:0] fwd_data2
);
    logic [1:0]    gnt;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d, win_addr;
    logic [DW-1:0] data_q, data_d;

    // Reset also masks grants so no handshake completes while the block is in reset
    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .hold (hold | rst),
        .req  ({wb1_valid, wb0_valid}),
        .gnt  (gnt)
    );

    assign wb0_ready = gnt[0];
    assign wb1_ready = gnt[1];

    // Stage the winner; writes to $0 handshake normally but never raise the write enable
    always_comb begin
        win_addr = gnt[1] ? wb1_addr : wb0_addr;
        we_d     = |gnt && (win_addr != AW'(REG_ZERO));
        addr_d   = |gnt ? win_addr : addr_q;
        data_d   = |gnt ? (gnt[1] ? wb1_data : wb0_data) : data_q;
    end

    // Output stage drains every cycle since gpr commits unconditionally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign SIG_RF_W   = we_q;
    assign reg_write  = addr_q;
    assign data_write = data_q;

    // Staged-but-uncommitted write is visible to readers; $0 never forwards
    always_comb begin
        fwd_hit1  = we_q && (addr_q == rd_addr1) && (rd_addr1 != AW'(REG_ZERO));
        fwd_hit2  = we_q && (addr_q == rd_addr2) && (rd_addr2 != AW'(REG_ZERO));
        fwd_data1 = fwd_hit1 ? data_q : '0;
        fwd_data2 = fwd_hit2 ? data_q : '0;
    end
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed self-checking bench for gpr_wb_arbiter with a stand-in gpr
module tb_gpr_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst, hold;
    logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [4:0]  wb0_addr, wb1_addr, reg_write, rd_addr1, rd_addr2;
    logic [31:0] wb0_data, wb1_data, data_write, fwd_data1, fwd_data2;
    logic        SIG_RF_W, fwd_hit1, fwd_hit2;
    logic [31:0] rf [32] = '{default: '0};
    int          checks = 0;
    int          errors = 0;
    int          k0, k1;

    always #5 clk = ~clk;

    gpr_wb_arbiter dut (
        .clk(clk), .rst(rst), .hold(hold),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .SIG_RF_W(SIG_RF_W), .reg_write(reg_write), .data_write(data_write),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    // Stand-in gpr: commits the staged write every edge, r0 hardwired to zero
    always @(posedge clk) if (SIG_RF_W && reg_write != 5'd0) rf[reg_write] <= data_write;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0;
        wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h33;
        wb1_valid = 1'b1; wb1_addr = 5'd4; wb1_data = 32'h44;
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        #3;
        chk("rst_rdy0", wb0_ready, 0);
        chk("rst_rdy1", wb1_ready, 0);
        chk("rst_we", SIG_RF_W, 0);
        chk("rst_addr", reg_write, 0);
        chk("rst_data", data_write, 0);
        chk("rst_hit1", fwd_hit1, 0);
        chk("rst_fwd1", fwd_data1, 0);
        tick;
        rst = 1'b0;
        #1;
        chk("tie0_rdy0", wb0_ready, 1);
        chk("tie0_rdy1", wb1_ready, 0);
        tick;
        chk("tie0_we", SIG_RF_W, 1);
        chk("tie0_addr", reg_write, 3);
        chk("tie0_data", data_write, 32'h33);
        chk("tie1_rdy1", wb1_ready, 1);
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        tick;
        chk("drain_we", SIG_RF_W, 0);
        chk("drain_addr_hold", reg_write, 3);
        chk("rf3", rf[3], 32'h33);
        // single requester
        wb1_valid = 1'b1; wb1_addr = 5'd5; wb1_data = 32'hDEAD_BEEF;
        #1;
        chk("single_rdy1", wb1_ready, 1);
        chk("single_rdy0", wb0_ready, 0);
        tick;
        wb1_valid = 1'b0;
        chk("single_we", SIG_RF_W, 1);
        chk("single_addr", reg_write, 5);
        chk("single_data", data_write, 32'hDEAD_BEEF);
        tick;
        chk("single_we_off", SIG_RF_W, 0);
        chk("rf5", rf[5], 32'hDEAD_BEEF);
        // contention: req0 serves odd addresses, req1 even ones
        k0 = 1; k1 = 2;
        wb0_valid = 1'b1; wb1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wb0_addr = 5'(k0); wb0_data = 32'h100 + 32'(k0);
            wb1_addr = 5'(k1); wb1_data = 32'h100 + 32'(k1);
            #1;
            chk($sformatf("cont%0d_rdy0", i), wb0_ready, 32'(i % 2 == 0));
            chk($sformatf("cont%0d_rdy1", i), wb1_ready, 32'(i % 2 == 1));
            tick;
            if (i % 2 == 0) k0 += 2; else k1 += 2;
        end
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        tick;
        for (int j = 1; j <= 6; j++) chk($sformatf("cont_rf%0d", j), rf[j], 32'h100 + 32'(j));
        // write to $0
        wb0_valid = 1'b1; wb0_addr = 5'd0; wb0_data = 32'h1234; rd_addr1 = 5'd0;
        #1;
        chk("zero_rdy0", wb0_ready, 1);
        tick;
        wb0_valid = 1'b0;
        chk("zero_we", SIG_RF_W, 0);
        chk("zero_hit1", fwd_hit1, 0);
        chk("zero_data", data_write, 32'h1234);
        tick;
        chk("zero_rf0", rf[0], 0);
        // forwarding
        wb1_valid = 1'b1; wb1_addr = 5'd7; wb1_data = 32'hCAFE;
        rd_addr1 = 5'd7; rd_addr2 = 5'd8;
        tick;
        wb1_valid = 1'b0;
        chk("fwd_hit1", fwd_hit1, 1);
        chk("fwd_data1", fwd_data1, 32'hCAFE);
        chk("fwd_hit2", fwd_hit2, 0);
        chk("fwd_data2", fwd_data2, 0);
        tick;
        chk("fwd_hit1_off", fwd_hit1, 0);
        chk("fwd_data1_off", fwd_data1, 0);
        chk("rf7", rf[7], 32'hCAFE);
        // hold rises while a req1 write is staged
        wb1_valid = 1'b1; wb1_addr = 5'd9; wb1_data = 32'h99;
        tick;
        hold = 1'b1;
        wb0_valid = 1'b1; wb0_addr = 5'd10; wb0_data = 32'hAA;
        wb1_addr = 5'd11; wb1_data = 32'hBB;
        chk("hold_staged_we", SIG_RF_W, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("hold%0d_rdy0", i), wb0_ready, 0);
            chk($sformatf("hold%0d_rdy1", i), wb1_ready, 0);
            tick;
        end
        chk("hold_rf9", rf[9], 32'h99);
        chk("hold_we_off", SIG_RF_W, 0);
        hold = 1'b0;
        #1;
        chk("unhold_rdy0", wb0_ready, 1);
        chk("unhold_rdy1", wb1_ready, 0);
        tick;
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        chk("unhold_we", SIG_RF_W, 1);
        chk("unhold_addr", reg_write, 10);
        // mid-op reset while the r10 write is staged
        #2 rst = 1'b1;
        #1;
        chk("midrst_we", SIG_RF_W, 0);
        wb0_valid = 1'b1; wb1_valid = 1'b1;
        #1;
        chk("midrst_rdy0", wb0_ready, 0);
        tick;
        rst = 1'b0;
        #1;
        chk("midrst_rf10", rf[10], 0);
        chk("postrst_rdy0", wb0_ready, 1);
        chk("postrst_rdy1", wb1_ready, 0);
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
